// File: rtl/pe_cmd_dispatch_if.sv
// pe_cmd_dispatch_if: scheduler command, PE core issue and status response channels of the dispatcher.
// master = dispatcher side, slave = scheduler/core side.
interface pe_cmd_dispatch_if #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned VECTOR_WIDTH = 32
);
   localparam int unsigned VEC_W = DATA_WIDTH * VECTOR_WIDTH;

   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_instr;
   logic [VEC_W-1:0] cmd_data;

   logic             pe_start;
   logic [31:0]      pe_instruction;
   logic [VEC_W-1:0] pe_data;
   logic             pe_done;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_status;
   logic [3:0]       rsp_opcode;

   modport master (
      input  cmd_valid, cmd_instr, cmd_data, pe_done, rsp_ready,
      output cmd_ready, pe_start, pe_instruction, pe_data, rsp_valid, rsp_status, rsp_opcode
   );

   modport slave (
      output cmd_valid, cmd_instr, cmd_data, pe_done, rsp_ready,
      input  cmd_ready, pe_start, pe_instruction, pe_data, rsp_valid, rsp_status, rsp_opcode
   );
endinterface

// File: rtl/pe_cmd_dispatch.sv
// pe_cmd_dispatch: command FIFO + issue FSM in front of the PE core; one status response per command.
// Define PE_DISPATCH_PERF_EN to add the perf_issued/perf_timeouts/perf_stall counters.
module pe_cmd_dispatch #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned VECTOR_WIDTH   = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   pe_cmd_dispatch_if.master            bus,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         busy
`ifdef PE_DISPATCH_PERF_EN
   ,
   output logic [31:0]                  perf_issued,
   output logic [15:0]                  perf_timeouts,
   output logic [31:0]                  perf_stall
`endif
);
   localparam int unsigned VEC_W = DATA_WIDTH * VECTOR_WIDTH;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_ILLEGAL = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state, state_nx;

   logic [31:0]      fifo_instr [FIFO_DEPTH];
   logic [VEC_W-1:0] fifo_data  [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_nx;
   logic [TMR_W-1:0] timer, timer_nx;
   logic [3:0]       head_op;
   logic             push, pop, issue_ld;
   logic [1:0]       status_nx;

   logic             pe_start_q;
   logic [31:0]      pe_instr_q;
   logic [VEC_W-1:0] pe_data_q;
   logic             rsp_valid_q;
   logic [1:0]       rsp_status_q;
   logic [3:0]       rsp_opcode_q;

   // Ready depends on occupancy only, so a pop never frees a slot in the same cycle.
   assign bus.cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign head_op       = fifo_instr[rd_ptr][31:28];
   assign count_nx      = fifo_count + CNT_W'(push) - CNT_W'(pop);

   assign bus.pe_start       = pe_start_q;
   assign bus.pe_instruction = pe_instr_q;
   assign bus.pe_data        = pe_data_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_status     = rsp_status_q;
   assign bus.rsp_opcode     = rsp_opcode_q;

   // Next-state, pop decision, timer and response status.
   always_comb begin
      state_nx  = state;
      timer_nx  = timer;
      status_nx = rsp_status_q;
      pop       = 1'b0;
      issue_ld  = 1'b0;
      case (state)
         S_IDLE: begin
            if (fifo_count != '0) begin
               pop = 1'b1;
               if (head_op < 4'd4) begin
                  state_nx = S_ISSUE;
                  issue_ld = 1'b1;
               end else begin
                  state_nx  = S_RESP;
                  status_nx = ST_ILLEGAL;
               end
            end
         end
         S_ISSUE: begin
            timer_nx = '0;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            timer_nx = timer + TMR_W'(1);
            if (bus.pe_done) begin
               state_nx  = S_RESP;
               status_nx = ST_OK;
            end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               state_nx  = S_RESP;
               status_nx = ST_TIMEOUT;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         timer        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         busy         <= 1'b0;
         pe_start_q   <= 1'b0;
         pe_instr_q   <= '0;
         pe_data_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= '0;
         rsp_opcode_q <= '0;
      end else begin
         state        <= state_nx;
         timer        <= timer_nx;
         fifo_count   <= count_nx;
         busy         <= (state_nx != S_IDLE) || (count_nx != '0);
         pe_start_q   <= (state_nx == S_ISSUE);
         rsp_valid_q  <= (state_nx == S_RESP);
         rsp_status_q <= status_nx;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr       <= rd_ptr + PTR_W'(1);
            rsp_opcode_q <= head_op;
         end
         // Core-facing copies change only when a legal command is issued.
         if (issue_ld) begin
            pe_instr_q <= fifo_instr[rd_ptr];
            pe_data_q  <= fifo_data[rd_ptr];
         end
      end
   end

   // Queue storage.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.cmd_instr;
         fifo_data[wr_ptr]  <= bus.cmd_data;
      end
   end

`ifdef PE_DISPATCH_PERF_EN
   // Issue/stall counters wrap; timeout counter saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issued   <= '0;
         perf_timeouts <= '0;
         perf_stall    <= '0;
      end else begin
         if (pe_start_q) perf_issued <= perf_issued + 32'd1;
         if ((state == S_WAIT) && (state_nx == S_RESP) && (status_nx == ST_TIMEOUT)
             && (perf_timeouts != 16'hFFFF))
            perf_timeouts <= perf_timeouts + 16'd1;
         if (bus.cmd_valid && !bus.cmd_ready) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
